// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response plus decode-side handshake.
interface if_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_plus_4;

    modport master (
        output imem_req, imem_addr,
        output out_valid, out_instr, out_pc, out_pc_plus_4,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        input  out_valid, out_instr, out_pc, out_pc_plus_4,
        output imem_ack, imem_rdata, out_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry {pc,instr} prefetch queue.
// Define IF_PERF_CNT_EN to add perf_fetched / perf_discarded counters.
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    if_fetch_queue_if.master        bus,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_discarded,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic              push, pop, issue;
    logic [NW-1:0]     next_cnt;
    logic [ADDR_W-1:0] pc_next;

    assign pop      = (cnt_q != '0) && bus.out_ready;
    assign push     = bus.imem_ack && (state_q == S_WAIT) && !redirect;
    assign next_cnt = {1'b0, cnt_q} + NW'(push) - NW'(pop);
    assign issue    = !stall && !redirect && (next_cnt < NW'(DEPTH));
    assign pc_next  = fetch_pc_q + ADDR_W'(PC_INC);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        cnt_d      = next_cnt[CW-1:0];
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        if (redirect) begin
            cnt_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
            fetch_pc_d = redirect_pc;
        end
        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (bus.imem_ack) begin
                    if (redirect) begin
                        state_d = S_IDLE;
                    end else begin
                        fetch_pc_d = pc_next;
                        if (issue) addr_d = pc_next;
                        else       state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]    <= addr_q;
            instr_mem[wr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req      = (state_q != S_IDLE);
    assign bus.imem_addr     = addr_q;
    assign bus.out_valid     = (cnt_q != '0);
    assign bus.out_instr     = instr_mem[rd_q];
    assign bus.out_pc        = pc_mem[rd_q];
    assign bus.out_pc_plus_4 = pc_mem[rd_q] + ADDR_W'(PC_INC);
    assign fifo_count        = cnt_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, discarded_q;
    logic        drop;

    assign drop = bus.imem_ack &&
                  ((state_q == S_DISCARD) ||
                   ((state_q == S_WAIT) && redirect));

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            if (push && (fetched_q != '1))
                fetched_q <= fetched_q + 32'd1;
            if (drop && (discarded_q != '1))
                discarded_q <= discarded_q + 32'd1;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_discarded = discarded_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table, directed corners, random vs model.
module tb_if_fetch_queue;
    localparam logic [31:0] K_X   = 32'h1357_9BDF;
    localparam logic [31:0] K_BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  fc;
    logic [2:0]  fc_s;
    bit          zw, xm, bad, ack_b, ready;
`ifdef IF_PERF_CNT_EN
    logic [31:0] pf, pd, pf_s, pd_s;
`endif

    int vectors = 0;
    int miscompares = 0;

    if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) b ();
    if_fetch_queue_if #(.ADDR_W(8), .DATA_W(8)) s ();

    always #5 clk = ~clk;

    assign b.imem_ack   = zw ? b.imem_req : ack_b;
    assign b.imem_rdata = bad ? K_BAD :
                          (xm ? (b.imem_addr ^ K_X) : b.imem_addr);
    assign b.out_ready  = ready;
    assign s.imem_ack   = s.imem_req;
    assign s.imem_rdata = s.imem_addr;
    assign s.out_ready  = 1'b1;

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .bus(b),
`ifdef IF_PERF_CNT_EN
        .perf_fetched(pf), .perf_discarded(pd),
`endif
        .fifo_count(fc)
    );

    if_fetch_queue #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(4), .RESET_PC(8'hFC)
    ) dut_s (
        .clk(clk), .reset(reset), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(8'h00),
        .bus(s),
`ifdef IF_PERF_CNT_EN
        .perf_fetched(pf_s), .perf_discarded(pd_s),
`endif
        .fifo_count(fc_s)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ack_b = 1'b0; bad = 1'b0; zw = 1'b0; xm = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, b.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, b.out_valid}, 32'd0);
        chk("rst_cnt", {29'd0, fc}, 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy, mstale;
    logic [31:0] mfpc, mraddr;
    int          lat;

    task automatic m_reset();
        mq.delete();
        mbusy = 0; mstale = 0; mfpc = '0; mraddr = '0;
    endtask

    task automatic m_step(input bit st, input bit rd, input logic [31:0] rpc,
                          input bit ak, input bit rdy, output bit iss);
        bit wb, ws, can;
        ent_t e;
        wb = mbusy;
        ws = mstale;
        if (rd) begin
            mq.delete();
            mfpc = rpc;
            if (wb && ak) begin mbusy = 0; mstale = 0; end
            else if (wb) mstale = 1;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (wb && ak) begin
                mbusy = 0;
                if (!ws) begin
                    e.pc = mraddr;
                    e.ins = mraddr ^ K_X;
                    mq.push_back(e);
                    mfpc = mfpc + 32'd4;
                end
            end
        end
        can = !wb || (ak && !ws);
        iss = can && !st && !rd && (mq.size() < 4);
        if (iss) begin mbusy = 1; mstale = 0; mraddr = mfpc; end
    endtask

    task automatic m_check();
        chk("r_req", {31'd0, b.imem_req}, {31'd0, mbusy});
        if (mbusy) chk("r_addr", b.imem_addr, mraddr);
        chk("r_valid", {31'd0, b.out_valid}, {31'd0, mq.size() > 0});
        chk("r_cnt", {29'd0, fc}, mq.size());
        if (mq.size() > 0) begin
            chk("r_pc", b.out_pc, mq[0].pc);
            chk("r_instr", b.out_instr, mq[0].ins);
            chk("r_pc4", b.out_pc_plus_4, mq[0].pc + 32'd4);
        end
    endtask

    typedef struct {
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit st, rd, rdy, ak, iss;
        logic [31:0] rpc;

        tbl[0]  = '{1, 0, 0,     1, 32'h000, 0, 0,       0};
        tbl[1]  = '{1, 0, 0,     1, 32'h004, 1, 32'h000, 1};
        tbl[2]  = '{1, 0, 0,     1, 32'h008, 1, 32'h004, 1};
        tbl[3]  = '{0, 0, 0,     1, 32'h00C, 1, 32'h008, 1};
        tbl[4]  = '{0, 0, 0,     1, 32'h010, 1, 32'h008, 2};
        tbl[5]  = '{0, 0, 0,     1, 32'h014, 1, 32'h008, 3};
        tbl[6]  = '{0, 0, 0,     0, 0,       1, 32'h008, 4};
        tbl[7]  = '{1, 0, 0,     0, 0,       1, 32'h008, 4};
        tbl[8]  = '{0, 0, 0,     1, 32'h018, 1, 32'h00C, 3};
        tbl[9]  = '{0, 0, 0,     0, 0,       1, 32'h00C, 4};
        tbl[10] = '{1, 1, 32'h100, 0, 0,     1, 32'h00C, 4};
        tbl[11] = '{1, 0, 0,     0, 0,       0, 0,       0};
        tbl[12] = '{1, 0, 0,     1, 32'h100, 0, 0,       0};
        tbl[13] = '{1, 1, 32'h200, 1, 32'h104, 1, 32'h100, 1};
        tbl[14] = '{1, 0, 0,     0, 0,       0, 0,       0};
        tbl[15] = '{1, 0, 0,     1, 32'h200, 0, 0,       0};

        do_reset();
        zw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("t%0d_req", i), {31'd0, b.imem_req},
                {31'd0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("t%0d_addr", i), b.imem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_valid", i), {31'd0, b.out_valid},
                {31'd0, tbl[i].e_valid});
            chk($sformatf("t%0d_cnt", i), {29'd0, fc}, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i), b.out_pc, tbl[i].e_pc);
                chk($sformatf("t%0d_instr", i), b.out_instr, tbl[i].e_pc);
                chk($sformatf("t%0d_pc4", i), b.out_pc_plus_4,
                    tbl[i].e_pc + 32'd4);
            end
            ready = tbl[i].rdy;
            redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
        end

        // Redirect mid-wait: stale response must be dropped.
        do_reset();
        @(negedge clk);
        chk("dc_req0", {31'd0, b.imem_req}, 32'd1);
        chk("dc_addr0", b.imem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("dc_hold", {31'd0, b.imem_req}, 32'd1);
        chk("dc_hold_a", b.imem_addr, 32'h0);
        redirect = 1'b0;
        @(negedge clk);
        chk("dc_req2", {31'd0, b.imem_req}, 32'd1);
        ack_b = 1'b1; bad = 1'b1;
        @(negedge clk);
        chk("dc_idle", {31'd0, b.imem_req}, 32'd0);
        chk("dc_nov", {31'd0, b.out_valid}, 32'd0);
        chk("dc_cnt", {29'd0, fc}, 32'd0);
        ack_b = 1'b0; bad = 1'b0;
        @(negedge clk);
        chk("dc_addr", b.imem_addr, 32'h100);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("dc_valid", {31'd0, b.out_valid}, 32'd1);
        chk("dc_pc", b.out_pc, 32'h100);
        chk("dc_instr", b.out_instr, 32'h100);

        // Stall with an outstanding request.
        do_reset();
        @(negedge clk);
        chk("st_req0", {31'd0, b.imem_req}, 32'd1);
        stall = 1'b1;
        @(negedge clk);
        chk("st_req1", {31'd0, b.imem_req}, 32'd1);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("st_done", {31'd0, b.imem_req}, 32'd0);
        chk("st_cnt", {29'd0, fc}, 32'd1);
        chk("st_pc", b.out_pc, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("st_noreq", {31'd0, b.imem_req}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("st_resume", {31'd0, b.imem_req}, 32'd1);
        chk("st_raddr", b.imem_addr, 32'h4);

        // Reset during a wait; the late ack is ignored.
        do_reset();
        @(negedge clk);
        chk("rw_req", {31'd0, b.imem_req}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rw_req0", {31'd0, b.imem_req}, 32'd0);
        chk("rw_v0", {31'd0, b.out_valid}, 32'd0);
        reset = 1'b1; ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("rw_v1", {31'd0, b.out_valid}, 32'd0);
        chk("rw_cnt", {29'd0, fc}, 32'd0);
        chk("rw_addr", b.imem_addr, 32'h0);
        @(negedge clk);
        chk("rw_v2", {31'd0, b.out_valid}, 32'd0);

        // 8-bit PC wrap on the second instance.
        do_reset();
        @(negedge clk);
        chk("w_addr", {24'd0, s.imem_addr}, 32'hFC);
        @(negedge clk);
        chk("w_pc0", {24'd0, s.out_pc}, 32'hFC);
        chk("w_pc4", {24'd0, s.out_pc_plus_4}, 32'h00);
        chk("w_ins0", {24'd0, s.out_instr}, 32'hFC);
        @(negedge clk);
        chk("w_pc1", {24'd0, s.out_pc}, 32'h00);
        chk("w_pc41", {24'd0, s.out_pc_plus_4}, 32'h04);

        // Random traffic against the queue model.
        do_reset();
        xm = 1'b1;
        m_reset();
        m_step(0, 0, '0, 0, 0, iss);
        if (iss) lat = $urandom_range(0, 3);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            m_check();
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            rdy = ($urandom_range(0, 9) < 6);
            ak  = mbusy && (lat == 0);
            if (mbusy && !ak) lat--;
            stall = st; redirect = rd; redirect_pc = rpc;
            ack_b = ak; ready = rdy;
            m_step(st, rd, rpc, ak, rdy, iss);
            if (iss) lat = $urandom_range(0, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
